// File: rtl/encode_4_2_seq.sv
// -----------------------------------------------------------------------------
// encode_4_2_seq
//   Registered request encoder (inverse of a 2x4 decoder). Request strobes on I
//   are collected into a pending mask; one binary index per grant is offered on
//   Y with a Vld/Rdy handshake, so N_IN request lines share one IDX_W-bit
//   select bus.
//
// Ports
//   clk  in   1      clock, all state on rising edge
//   rst  in   1      asynchronous, active-high reset
//   En   in   1      request enable; I ignored when En=0
//   I    in   N_IN   request strobes, sampled every cycle
//   Rdy  in   1      consumer ready
//   Vld  out  1      Y holds a valid encoded index
//   Y    out  IDX_W  encoded index of the granted request
//   Ovf  out  1      1-cycle pulse: a request hit an already-pending bit
//
// Configuration macro
//   RR_PRIO_EN  defined   : round-robin selection starting after the last
//                           granted index (rr_last), ascending with wrap.
//               undefined : fixed priority, highest index wins.
// -----------------------------------------------------------------------------
module encode_4_2_seq #(
  parameter int N_IN  = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic [N_IN-1:0]  I,
  input  logic             Rdy,
  output logic             Vld,
  output logic [IDX_W-1:0] Y,
  output logic             Ovf
);

  typedef enum logic {IDLE = 1'b0, SEL = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] y_nxt;

  logic [N_IN-1:0]  pend;
  logic [N_IN-1:0]  req;
  logic [N_IN-1:0]  clr;
  logic [N_IN-1:0]  rem;
  logic [N_IN-1:0]  pend_nxt;
  logic             hs;

  logic [IDX_W-1:0] pick_pend;
  logic [IDX_W-1:0] pick_rem;

`ifdef RR_PRIO_EN
  logic [IDX_W-1:0] rr_last;

  // Ascending search starting one past 'last'; k=N_IN wraps back onto 'last'
  // itself so every line is examined exactly once.
  function automatic logic [IDX_W-1:0] sel_rr(input logic [N_IN-1:0]  v,
                                              input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] r;
    logic [IDX_W-1:0] idx;
    logic             found;
    r     = '0;
    found = 1'b0;
    for (int k = 1; k <= N_IN; k++) begin
      idx = last + IDX_W'(k);
      if (!found && v[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // After a handshake the index just granted becomes the new search origin,
  // matching the rr_last update on the same edge.
  assign pick_pend = sel_rr(pend, rr_last);
  assign pick_rem  = sel_rr(rem, Y);
`else
  // Fixed priority: later (higher) indices overwrite earlier hits.
  function automatic logic [IDX_W-1:0] sel_fixed(input logic [N_IN-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign pick_pend = sel_fixed(pend);
  assign pick_rem  = sel_fixed(rem);
`endif

  // Capture / clear datapath. A new request on the bit being granted this
  // cycle survives the clear (set wins) and does not count as an overflow.
  assign hs       = Vld & Rdy;
  assign req      = I & {N_IN{En}};
  assign clr      = hs ? (N_IN'(1) << Y) : '0;
  assign rem      = pend & ~clr;
  assign pend_nxt = rem | req;

  // State register plus the registered datapath outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
      Y     <= '0;
      Ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      Y     <= y_nxt;
      Ovf   <= |(req & rem);
    end
  end

`ifdef RR_PRIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= IDX_W'(N_IN - 1);
    end else if (hs) begin
      rr_last <= Y;
    end
  end
`endif

  // Next-state: selection only ever looks at the registered pend, so a new
  // strobe is granted no earlier than one cycle after it is captured.
  always_comb begin
    state_nxt = state;
    y_nxt     = Y;
    case (state)
      IDLE: begin
        if (|pend) begin
          state_nxt = SEL;
          y_nxt     = pick_pend;
        end
      end
      SEL: begin
        // Y is frozen while the consumer stalls.
        if (hs) begin
          if (|rem) begin
            y_nxt = pick_rem;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    Vld = (state == SEL);
  end

endmodule

// File: tb/tb_encode_4_2_seq.sv
module tb_encode_4_2_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       En  = 1'b0;
  logic [3:0] I   = 4'b0000;
  logic       Rdy = 1'b0;
  logic       Vld;
  logic [1:0] Y;
  logic       Ovf;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  encode_4_2_seq #(.N_IN(4), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .En(En), .I(I), .Rdy(Rdy),
    .Vld(Vld), .Y(Y), .Ovf(Ovf)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference ----------------
  // Pending requests are a plain integer mask; a grant is offered whenever
  // one is outstanding, and a taken grant removes its bit.
  int m_pend;
  int m_y;
  int m_last;
  bit m_vld;
  bit m_ovf;

  function automatic int pick(int v, int last);
    for (int k = 0; k < 4; k++) begin
      int idx;
`ifdef RR_PRIO_EN
      idx = (last + 1 + k) % 4;
`else
      idx = 3 - k + (last * 0);
`endif
      if (((v >> idx) & 1) != 0) return idx;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin : mdl
    int req, clr, rem, nv, ny;
    if (rst) begin
      m_pend <= 0;
      m_vld  <= 1'b0;
      m_y    <= 0;
      m_ovf  <= 1'b0;
      m_last <= 3;
    end else begin
      req = En ? int'(I) : 0;
      clr = (m_vld && Rdy) ? (1 << m_y) : 0;
      rem = m_pend & ~clr;
      nv  = int'(m_vld);
      ny  = m_y;
      if (!m_vld) begin
        if (m_pend != 0) begin
          nv = 1;
          ny = pick(m_pend, m_last);
        end
      end else if (Rdy) begin
        if (rem != 0) ny = pick(rem, m_y);
        else          nv = 0;
      end
      if (m_vld && Rdy) m_last <= m_y;
      m_ovf  <= ((req & rem) != 0);
      m_pend <= (rem | req) & 15;
      m_vld  <= (nv != 0);
      m_y    <= ny;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the reference
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_vld", {31'd0, Vld}, {31'd0, m_vld});
      chk("model_y",   {30'd0, Y},   32'(m_y));
      chk("model_ovf", {31'd0, Ovf}, {31'd0, m_ovf});
    end
  end

  // Inputs change at the falling edge; the task returns at the next falling
  // edge, where the outputs reflect the rising edge that sampled them.
  task automatic step(input logic en, input logic [3:0] i, input logic rdy);
    En  = en;
    I   = i;
    Rdy = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    En  = 1'b0;
    I   = 4'b0000;
    Rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int exp6 [4];

  initial begin
    @(negedge clk);
    do_reset();
    chk_on = 1'b1;
    chk("rst_vld", {31'd0, Vld}, 32'd0);
    chk("rst_y",   {30'd0, Y},   32'd0);
    chk("rst_ovf", {31'd0, Ovf}, 32'd0);

    // 1: async reset while holding a grant with pend=1010
    step(1'b1, 4'b1010, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    chk("t1_pre_vld", {31'd0, Vld}, 32'd1);
    chk("t1_pre_y",   {30'd0, Y},   32'd3);
    #2 rst = 1'b1;
    #1;
    chk("t1_vld", {31'd0, Vld}, 32'd0);
    chk("t1_y",   {30'd0, Y},   32'd0);
    chk("t1_ovf", {31'd0, Ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0000, 1'b1);
      chk("t1_after_vld", {31'd0, Vld}, 32'd0);
    end

    // 2: single strobe, consumer ready
    do_reset();
    step(1'b1, 4'b0100, 1'b1);
    chk("t2_lat_vld", {31'd0, Vld}, 32'd0);
    step(1'b0, 4'b0000, 1'b1);
    chk("t2_vld", {31'd0, Vld}, 32'd1);
    chk("t2_y",   {30'd0, Y},   32'd2);
    step(1'b0, 4'b0000, 1'b1);
    chk("t2_done", {31'd0, Vld}, 32'd0);

    // 3: stall then two back-to-back handshakes
    do_reset();
    step(1'b1, 4'b1010, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0000, 1'b0);
      chk("t3_hold_vld", {31'd0, Vld}, 32'd1);
      chk("t3_hold_y",   {30'd0, Y},   32'd3);
    end
    step(1'b0, 4'b0000, 1'b1);
    chk("t3_b2_vld", {31'd0, Vld}, 32'd1);
    chk("t3_b2_y",   {30'd0, Y},   32'd1);
    step(1'b0, 4'b0000, 1'b1);
    chk("t3_idle", {31'd0, Vld}, 32'd0);

    // 4: requests gated off
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b1111, 1'b1);
      chk("t4_vld", {31'd0, Vld}, 32'd0);
      chk("t4_ovf", {31'd0, Ovf}, 32'd0);
    end

    // 5: merge into pending bit, then re-request during its handshake
    do_reset();
    step(1'b1, 4'b0100, 1'b0);
    chk("t5_ovf0", {31'd0, Ovf}, 32'd0);
    step(1'b1, 4'b0100, 1'b0);
    chk("t5_ovf1", {31'd0, Ovf}, 32'd1);
    chk("t5_y",    {30'd0, Y},   32'd2);
    step(1'b0, 4'b0000, 1'b0);
    chk("t5_ovf_pulse", {31'd0, Ovf}, 32'd0);
    step(1'b1, 4'b0100, 1'b1);
    chk("t5_hs_ovf", {31'd0, Ovf}, 32'd0);
    chk("t5_hs_vld", {31'd0, Vld}, 32'd0);
    step(1'b0, 4'b0000, 1'b1);
    chk("t5_g2_vld", {31'd0, Vld}, 32'd1);
    chk("t5_g2_y",   {30'd0, Y},   32'd2);
    step(1'b0, 4'b0000, 1'b1);
    chk("t5_end", {31'd0, Vld}, 32'd0);

    // 6: all four lines at once
    do_reset();
`ifdef RR_PRIO_EN
    exp6 = '{0, 1, 2, 3};
`else
    exp6 = '{3, 2, 1, 0};
`endif
    step(1'b1, 4'b1111, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'b0000, 1'b1);
      chk("t6_vld", {31'd0, Vld}, 32'd1);
      chk("t6_y",   {30'd0, Y},   32'(exp6[k]));
    end
    step(1'b0, 4'b0000, 1'b1);
    chk("t6_end", {31'd0, Vld}, 32'd0);

    // Random traffic, checked every cycle against the reference
    do_reset();
    for (int k = 0; k < 600; k++) begin
      logic       e;
      logic [3:0] r;
      logic       d;
      e = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      d = ($urandom_range(0, 2) != 0);
      if (k == 300) begin
        do_reset();
      end else begin
        step(e, r, d);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
